// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: holds the PC and issues one instruction read at a time.
// Returned words are buffered with their PC for decode.
// Redirects kill any in-flight fetch and restart fetching at the new PC.
module if_fetch_stage #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t          state, state_nx;
    logic [XLEN-1:0] pc, pc_nx;
    logic [XLEN-1:0] req_pc, req_pc_nx;
    logic            kill, kill_nx;
    logic            if_valid_nx;
    logic [XLEN-1:0] if_pc_nx;
    logic [31:0]     if_instr_nx;
    logic [XLEN-1:0] redirect_target;
    logic            req_fire;

    // Redirect target with the two low bits forced to zero
    assign redirect_target = redirect_pc & ~XLEN'(3);
    assign req_fire        = imem_req_valid && imem_req_ready;

    // Request channel: only in REQ, never during a redirect, and only when the buffer can take the result
    always_comb begin
        imem_req_valid = (state == REQ) && !redirect_valid && (!if_valid || if_ready);
        imem_req_addr  = pc;
    end

    // Next-state, PC, kill and output-buffer logic
    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        req_pc_nx   = req_pc;
        kill_nx     = kill;
        if_valid_nx = if_valid;
        if_pc_nx    = if_pc;
        if_instr_nx = if_instr;

        // Drain; a load or redirect below takes precedence
        if (if_valid && if_ready) begin
            if_valid_nx = 1'b0;
        end

        unique case (state)
            IDLE: begin
                state_nx = REQ;
            end
            REQ: begin
                if (redirect_valid) begin
                    pc_nx       = redirect_target;
                    if_valid_nx = 1'b0;
                end else if (req_fire) begin
                    req_pc_nx = pc;
                    pc_nx     = pc + XLEN'(4);
                    state_nx  = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_nx = REQ;
                    kill_nx  = 1'b0;
                    if (!kill && !redirect_valid) begin
                        if_valid_nx = 1'b1;
                        if_pc_nx    = req_pc;
                        if_instr_nx = imem_rsp_data;
                    end
                end
                // A redirect with no response this cycle leaves the old fetch outstanding,
                // so its response must be dropped when it returns
                if (redirect_valid) begin
                    pc_nx       = redirect_target;
                    if_valid_nx = 1'b0;
                    if (!imem_rsp_valid) begin
                        kill_nx = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_pc   <= '0;
            kill     <= 1'b0;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= '0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            req_pc   <= req_pc_nx;
            kill     <= kill_nx;
            if_valid <= if_valid_nx;
            if_pc    <= if_pc_nx;
            if_instr <= if_instr_nx;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: the bench plays instruction memory by hand.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_instr;

    int errors = 0;
    int checks = 0;

    if_fetch_stage #(
        .XLEN     (64),
        .RESET_PC (64'h0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if_ready       = 1'b0;
        #2;
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_if_valid",  64'(if_valid), 64'd0);
        chk("rst_if_pc",     if_pc, 64'h0);
        chk("rst_if_instr",  64'(if_instr), 64'h0);
        chk("rst_addr",      imem_req_addr, 64'h0);

        // Release reset; IDLE for one edge
        tick();
        rst_n = 1'b1; imem_req_ready = 1'b1; if_ready = 1'b1;
        #1;
        chk("idle_no_req", 64'(imem_req_valid), 64'd0);

        // First request at 0x0
        tick(); #1;
        chk("req0_valid", 64'(imem_req_valid), 64'd1);
        chk("req0_addr",  imem_req_addr, 64'h0);
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013; #1;
        chk("wait0_no_req", 64'(imem_req_valid), 64'd0);
        chk("wait0_if_valid", 64'(if_valid), 64'd0);
        tick();
        imem_rsp_valid = 1'b0; #1;
        chk("ld0_if_valid", 64'(if_valid), 64'd1);
        chk("ld0_if_pc",    if_pc, 64'h0);
        chk("ld0_if_instr", 64'(if_instr), 64'h13);
        chk("req4_valid",   64'(imem_req_valid), 64'd1);
        chk("req4_addr",    imem_req_addr, 64'h4);
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0093; #1;
        chk("drain0_if_valid", 64'(if_valid), 64'd0);
        tick();
        imem_rsp_valid = 1'b0; #1;
        chk("ld4_if_valid", 64'(if_valid), 64'd1);
        chk("ld4_if_pc",    if_pc, 64'h4);
        chk("ld4_if_instr", 64'(if_instr), 64'h0010_0093);
        chk("req8_addr",    imem_req_addr, 64'h8);
        chk("req8_valid",   64'(imem_req_valid), 64'd1);
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0020_0113; #1;
        chk("drain4_if_valid", 64'(if_valid), 64'd0);
        tick();
        imem_rsp_valid = 1'b0; if_ready = 1'b0; #1;
        chk("ld8_if_pc",    if_pc, 64'h8);
        chk("ld8_if_instr", 64'(if_instr), 64'h0020_0113);
        chk("bp_no_req",    64'(imem_req_valid), 64'd0);

        // Backpressure: buffer held, no request
        tick(); #1;
        chk("bp_hold_valid", 64'(if_valid), 64'd1);
        chk("bp_hold_pc",    if_pc, 64'h8);
        chk("bp_hold_noreq", 64'(imem_req_valid), 64'd0);
        if_ready = 1'b1; #1;
        chk("bp_release_valid", 64'(imem_req_valid), 64'd1);
        chk("bp_release_addr",  imem_req_addr, 64'hC);

        // Redirect to 0x1002 while waiting on the 0xC fetch
        tick();
        redirect_valid = 1'b1; redirect_pc = 64'h1002; #1;
        chk("rdw_no_req", 64'(imem_req_valid), 64'd0);
        tick();
        redirect_valid = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; #1;
        chk("rdw_still_wait", 64'(imem_req_valid), 64'd0);
        tick();
        imem_rsp_valid = 1'b0; #1;
        chk("rdw_dropped",   64'(if_valid), 64'd0);
        chk("rdw_req_valid", 64'(imem_req_valid), 64'd1);
        chk("rdw_req_addr",  imem_req_addr, 64'h1000);
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0030_0193; #1;
        tick();
        imem_rsp_valid = 1'b0; #1;
        chk("rdw_if_valid", 64'(if_valid), 64'd1);
        chk("rdw_if_pc",    if_pc, 64'h1000);
        chk("rdw_if_instr", 64'(if_instr), 64'h0030_0193);

        // Redirect while buffer is full and decode stalled
        if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h2000; #1;
        chk("rdf_no_req", 64'(imem_req_valid), 64'd0);
        tick();
        redirect_valid = 1'b0; #1;
        chk("rdf_flushed",   64'(if_valid), 64'd0);
        chk("rdf_req_valid", 64'(imem_req_valid), 64'd1);
        chk("rdf_req_addr",  imem_req_addr, 64'h2000);

        // Redirect coinciding with the response
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_1111;
        redirect_valid = 1'b1; redirect_pc = 64'h3007; #1;
        tick();
        imem_rsp_valid = 1'b0; redirect_valid = 1'b0; if_ready = 1'b1; #1;
        chk("rds_discard",   64'(if_valid), 64'd0);
        chk("rds_req_valid", 64'(imem_req_valid), 64'd1);
        chk("rds_req_addr",  imem_req_addr, 64'h3004);
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0040_0213; #1;
        tick();
        imem_rsp_valid = 1'b0; #1;
        chk("rds_if_valid", 64'(if_valid), 64'd1);
        chk("rds_if_pc",    if_pc, 64'h3004);
        chk("rds_if_instr", 64'(if_instr), 64'h0040_0213);

        // Redirect to the top of the address space; flush even with if_ready high
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF; #1;
        tick();
        redirect_valid = 1'b0; #1;
        chk("wrap_flushed",  64'(if_valid), 64'd0);
        chk("wrap_req_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0293; #1;
        tick();
        imem_rsp_valid = 1'b0; #1;
        chk("wrap_if_pc",     if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_if_instr",  64'(if_instr), 64'h0050_0293);
        chk("wrap_next_addr", imem_req_addr, 64'h0);
        chk("wrap_next_valid", 64'(imem_req_valid), 64'd1);
        tick(); #1;
        chk("wrap_wait_noreq", 64'(imem_req_valid), 64'd0);

        // Reset pulse while waiting; late response must be ignored
        rst_n = 1'b0; #1;
        chk("mrst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("mrst_if_valid",  64'(if_valid), 64'd0);
        chk("mrst_if_pc",     if_pc, 64'h0);
        chk("mrst_addr",      imem_req_addr, 64'h0);
        tick();
        rst_n = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBADB_ADBA; #1;
        tick();
        imem_rsp_valid = 1'b0; #1;
        chk("mrst_ignored",   64'(if_valid), 64'd0);
        chk("mrst_req_valid2", 64'(imem_req_valid), 64'd1);
        chk("mrst_req_addr",  imem_req_addr, 64'h0);
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013; #1;
        tick();
        imem_rsp_valid = 1'b0; if_ready = 1'b0; #1;
        chk("mrst_if_pc0",  if_pc, 64'h0);
        chk("mrst_bp_noreq", 64'(imem_req_valid), 64'd0);
        tick(); #1;
        chk("mrst_bp_hold", if_pc, 64'h0);
        chk("mrst_bp_valid", 64'(if_valid), 64'd1);
        if_ready = 1'b1; #1;
        chk("mrst_resume_valid", 64'(imem_req_valid), 64'd1);
        chk("mrst_resume_addr",  imem_req_addr, 64'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
